// File: rtl/ibuf_ctrl_if.sv
// Upstream element stream feeding the ibuf controller.
//   i_data_valid : element valid (producer -> controller)
//   i_data       : element payload (producer -> controller)
//   o_data_ready : controller accepts the element this cycle (controller -> producer)
// Signal names are taken from the controller's point of view.
interface ibuf_ctrl_if #(
    parameter int unsigned datatype_size = 8
);
    logic                     i_data_valid;
    logic [datatype_size-1:0] i_data;
    logic                     o_data_ready;

    // Producer side (host / DMA).
    modport master (
        output i_data_valid,
        output i_data,
        input  o_data_ready
    );

    // Controller side.
    modport slave (
        input  i_data_valid,
        input  i_data,
        output o_data_ready
    );
endinterface

// File: rtl/ibuf_ctrl.sv
// Input-buffer fill sequencer. Loads fifo_length elements per vector from the upstream stream
// straight into the ibuf (no local storage), triggers one CIM compute per vector, waits for the
// tile to report completion and repeats for the latched number of vectors in the job.
// Ports:
//   clk, rst        : clock, asynchronous active-high reset
//   i_job_start     : one-cycle job request, honoured only when idle
//   i_num_vectors   : vectors in the job, latched on an accepted start
//   up              : upstream valid/ready element stream (slave side)
//   o_ibuf_we       : ibuf write enable (= accepted element)
//   o_ibuf_data     : element forwarded to the ibuf
//   o_cim_start     : one-cycle compute trigger
//   i_cim_done      : one-cycle compute complete
//   o_vec_idx       : index of the vector being loaded / computed
//   o_busy          : high whenever not idle
//   o_job_done      : one-cycle job-complete pulse
module ibuf_ctrl #(
    parameter int unsigned datatype_size = 8,
    parameter int unsigned fifo_length   = 5,
    parameter int unsigned count_width   = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_job_start,
    input  logic [count_width-1:0]   i_num_vectors,
    ibuf_ctrl_if.slave               up,
    output logic                     o_ibuf_we,
    output logic [datatype_size-1:0] o_ibuf_data,
    output logic                     o_cim_start,
    input  logic                     i_cim_done,
    output logic [count_width-1:0]   o_vec_idx,
    output logic                     o_busy,
    output logic                     o_job_done
);

    localparam int unsigned ElemW = (fifo_length > 1) ? $clog2(fifo_length) : 1;
    localparam logic [ElemW-1:0] LastElem = ElemW'(fifo_length - 1);

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StIssue,
        StWait,
        StDone
    } state_e;

    state_e                 state_q, state_d;
    logic [ElemW-1:0]       elem_cnt_q, elem_cnt_d;
    logic [count_width-1:0] vec_cnt_q, vec_cnt_d;
    logic [count_width-1:0] num_vectors_q, num_vectors_d;

    logic ready;
    logic accept;

    assign ready  = (state_q == StLoad);
    assign accept = ready && up.i_data_valid;

    assign up.o_data_ready = ready;
    assign o_ibuf_we       = accept;
    // Forward only while loading so the ibuf data lines stay quiet (and zero in reset).
    assign o_ibuf_data     = ready ? up.i_data : '0;
    assign o_vec_idx       = vec_cnt_q;

    always_comb begin
        state_d       = state_q;
        elem_cnt_d    = elem_cnt_q;
        vec_cnt_d     = vec_cnt_q;
        num_vectors_d = num_vectors_q;
        o_cim_start   = 1'b0;
        o_busy        = 1'b1;
        o_job_done    = 1'b0;

        unique case (state_q)
            StIdle: begin
                o_busy = 1'b0;
                if (i_job_start) begin
                    num_vectors_d = i_num_vectors;
                    elem_cnt_d    = '0;
                    vec_cnt_d     = '0;
                    state_d       = (i_num_vectors != '0) ? StLoad : StDone;
                end
            end
            StLoad: begin
                if (accept) begin
                    if (elem_cnt_q == LastElem) begin
                        elem_cnt_d = '0;
                        state_d    = StIssue;
                    end else begin
                        elem_cnt_d = elem_cnt_q + 1'b1;
                    end
                end
            end
            StIssue: begin
                // A done coinciding with the trigger is not honoured here.
                o_cim_start = 1'b1;
                state_d     = StWait;
            end
            StWait: begin
                if (i_cim_done) begin
                    if (vec_cnt_q == num_vectors_q - 1'b1) begin
                        state_d = StDone;
                    end else begin
                        vec_cnt_d = vec_cnt_q + 1'b1;
                        state_d   = StLoad;
                    end
                end
            end
            StDone: begin
                o_job_done = 1'b1;
                state_d    = StIdle;
            end
            default: begin
                o_busy  = 1'b0;
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= StIdle;
            elem_cnt_q    <= '0;
            vec_cnt_q     <= '0;
            num_vectors_q <= '0;
        end else begin
            state_q       <= state_d;
            elem_cnt_q    <= elem_cnt_d;
            vec_cnt_q     <= vec_cnt_d;
            num_vectors_q <= num_vectors_d;
        end
    end

endmodule
